pt_fetcher: RTL and testbench

Read-modify-write sequencer between the projective transform and the `memory_interface` PTF port. It buffers transformed pixels (x, y, truncated value) in a small FIFO and packs each pixel into its half of a two-pixel SRAM word. Horizontally adjacent pixel pairs are coalesced into a single full-word write. It drives the `ptf_*` request lines of `memory_interface` and reads back through its read-return path.

---
 rtl/pt_fetcher.sv | 158 +++++++++++++++
 tb/tb_pt_fetcher.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pt_fetcher.sv
// rtl/pt_fetcher.sv - read-modify-write sequencer packing transformed pixels into two-pixel memory words
module pt_fetcher #(
   parameter int PIX_W      = 18,
   parameter int MEM_W      = 36,
   parameter int X_W        = 10,
   parameter int Y_W        = 9,
   parameter int FIFO_DEPTH = 4,
   parameter int READ_LAT   = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             frame_flag,
   input  logic             pt_flag,
   input  logic [X_W-1:0]   pt_x,
   input  logic [Y_W-1:0]   pt_y,
   input  logic [PIX_W-1:0] pt_pixel,
   output logic             done_pt,
   output logic             ptf_flag,
   output logic             ptf_wr,
   output logic [X_W-1:0]   ptf_x,
   output logic [Y_W-1:0]   ptf_y,
   output logic [MEM_W-1:0] ptf_pixel_write,
   input  logic             done_ptf,
   input  logic [MEM_W-1:0] ptf_pixel_read,
   output logic             busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(READ_LAT + 1);

   typedef enum logic [2:0] {S_IDLE, S_PAIR, S_RD_REQ, S_RD_WAIT, S_WR_REQ} state_t;
   state_t r_state, w_next;

   logic [X_W-1:0]   r_fx [FIFO_DEPTH];
   logic [Y_W-1:0]   r_fy [FIFO_DEPTH];
   logic [PIX_W-1:0] r_fp [FIFO_DEPTH];
   logic [AW:0]      r_wr_ptr, r_rd_ptr;
   logic [AW:0]      w_count, w_rd_ptr1;
   logic [AW-1:0]    w_h, w_n;
   logic             w_empty, w_full, w_push, w_pair, w_pop1, w_pop2;

   logic [X_W-1:0]   r_ptf_x;
   logic [Y_W-1:0]   r_ptf_y;
   logic [MEM_W-1:0] r_wdata;
   logic [LW-1:0]    r_lat;
   logic [PIX_W-1:0] r_work_pix;
   logic             r_work_x0;
   logic [MEM_W-1:0] w_pair_word, w_merged;

   assign w_h       = r_rd_ptr[AW-1:0];
   assign w_rd_ptr1 = r_rd_ptr + 1'b1;
   assign w_n       = w_rd_ptr1[AW-1:0];
   assign w_count   = r_wr_ptr - r_rd_ptr;
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // Head and head+1 land in opposite halves of the same word
   assign w_pair = (w_count >= (AW+1)'(2)) && (r_fy[w_h] == r_fy[w_n]) &&
                   (r_fx[w_h][X_W-1:1] == r_fx[w_n][X_W-1:1]) && (r_fx[w_h][0] != r_fx[w_n][0]);

   assign w_push  = reset & pt_flag & ~w_full & ~frame_flag;
   assign done_pt = w_push;

   assign w_pair_word = r_fx[w_h][0] ? {r_fp[w_n], r_fp[w_h]} : {r_fp[w_h], r_fp[w_n]};
   assign w_merged    = r_work_x0 ? {ptf_pixel_read[MEM_W-1:PIX_W], r_work_pix}
                                  : {r_work_pix, ptf_pixel_read[PIX_W-1:0]};

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fx[r_wr_ptr[AW-1:0]] <= pt_x;
         r_fy[r_wr_ptr[AW-1:0]] <= pt_y;
         r_fp[r_wr_ptr[AW-1:0]] <= pt_pixel;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (frame_flag) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop2) r_rd_ptr <= r_rd_ptr + (AW+1)'(2);
         else if (w_pop1) r_rd_ptr <= w_rd_ptr1;
      end
   end

   always_comb begin
      w_next = r_state;
      w_pop1 = 1'b0;
      w_pop2 = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               if (w_pair) begin
                  w_pop2 = 1'b1;
                  w_next = S_PAIR;
               end else begin
                  w_pop1 = 1'b1;
                  w_next = S_RD_REQ;
               end
            end
         end
         S_PAIR:    if (done_ptf) w_next = S_IDLE;
         S_RD_REQ:  if (done_ptf) w_next = S_RD_WAIT;
         S_RD_WAIT: if (r_lat == LW'(1)) w_next = S_WR_REQ;
         S_WR_REQ:  if (done_ptf) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
      if (frame_flag) begin
         w_next = S_IDLE;
         w_pop1 = 1'b0;
         w_pop2 = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_ptf_x    <= '0;
         r_ptf_y    <= '0;
         r_wdata    <= '0;
         r_lat      <= '0;
         r_work_pix <= '0;
         r_work_x0  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (!frame_flag) begin
            case (r_state)
               S_IDLE: begin
                  if (w_pop1 || w_pop2) begin
                     r_ptf_x    <= r_fx[w_h];
                     r_ptf_y    <= r_fy[w_h];
                     r_work_pix <= r_fp[w_h];
                     r_work_x0  <= r_fx[w_h][0];
                  end
                  if (w_pop2) r_wdata <= w_pair_word;
               end
               S_RD_REQ: if (done_ptf) r_lat <= LW'(READ_LAT);
               // Read data is valid only on the edge the countdown expires
               S_RD_WAIT: begin
                  r_lat <= r_lat - 1'b1;
                  if (r_lat == LW'(1)) r_wdata <= w_merged;
               end
               default: ;
            endcase
         end
      end
   end

   assign ptf_flag        = (r_state == S_PAIR) || (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
   assign ptf_wr          = (r_state == S_PAIR) || (r_state == S_WR_REQ);
   assign ptf_x           = r_ptf_x;
   assign ptf_y           = r_ptf_y;
   assign ptf_pixel_write = r_wdata;
   assign busy            = !w_empty || (r_state != S_IDLE);
endmodule

// File: tb/tb_pt_fetcher.sv
// tb/tb_pt_fetcher.sv - self-checking bench for pt_fetcher with a word-level memory model
module tb_pt_fetcher;
   localparam int PIX_W = 18, MEM_W = 36, X_W = 10, Y_W = 9, FIFO_DEPTH = 4, READ_LAT = 2;
   localparam logic [MEM_W-1:0] GARBAGE = 36'h5A5A5A5A5;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic frame_flag = 1'b0, pt_flag = 1'b0;
   logic [X_W-1:0] pt_x = '0;
   logic [Y_W-1:0] pt_y = '0;
   logic [PIX_W-1:0] pt_pixel = '0;
   logic done_pt, ptf_flag, ptf_wr, busy;
   logic [X_W-1:0] ptf_x;
   logic [Y_W-1:0] ptf_y;
   logic [MEM_W-1:0] ptf_pixel_write;
   logic done_ptf = 1'b0;
   logic [MEM_W-1:0] ptf_pixel_read = GARBAGE;

   pt_fetcher #(.PIX_W(PIX_W), .MEM_W(MEM_W), .X_W(X_W), .Y_W(Y_W),
                .FIFO_DEPTH(FIFO_DEPTH), .READ_LAT(READ_LAT)) dut (
      .clock(clock), .reset(reset), .frame_flag(frame_flag), .pt_flag(pt_flag),
      .pt_x(pt_x), .pt_y(pt_y), .pt_pixel(pt_pixel), .done_pt(done_pt),
      .ptf_flag(ptf_flag), .ptf_wr(ptf_wr), .ptf_x(ptf_x), .ptf_y(ptf_y),
      .ptf_pixel_write(ptf_pixel_write), .done_ptf(done_ptf),
      .ptf_pixel_read(ptf_pixel_read), .busy(busy));

   always #5 clock = ~clock;

   typedef struct { int x; int y; logic [PIX_W-1:0] p; } pix_t;
   pix_t mq[$];
   pix_t pa, pb;
   logic [MEM_W-1:0] mem [int];
   logic [MEM_W-1:0] exp_w;

   int checks = 0, failures = 0;
   int cyc = 0, req_age = 0, rd_cnt = 0, rd_key = 0, rd_data_key = 0, rg_cyc = 0;
   int rd_count = 0, wr_count = 0, wk = 0;
   int grant_en = 1, wr_grant_en = 1, stall_cfg = 0;
   bit rd_pending = 0, prev_hold = 0, prev_wr_req = 0, grant = 0;
   logic [X_W-1:0] h_x;
   logic [Y_W-1:0] h_y;
   logic h_wr;
   logic [MEM_W-1:0] h_wd;

   function automatic int key(input int x, input int y);
      return y * 1024 + (x >> 1);
   endfunction

   function automatic logic [MEM_W-1:0] mem_rd(input int k);
      if (mem.exists(k)) return mem[k];
      return '0;
   endfunction

   function automatic logic [MEM_W-1:0] place(input logic [MEM_W-1:0] w, input int x, input logic [PIX_W-1:0] p);
      if (x % 2 == 1) return {w[MEM_W-1:PIX_W], p};
      return {p, w[PIX_W-1:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task do_read();
      rd_count++;
      if (mq.size() == 0) check("read_unexpected", 1, 0);
      else begin
         check("rd_addr_y", 64'(ptf_y), 64'(mq[0].y));
         check("rd_addr_xw", 64'(ptf_x >> 1), 64'(mq[0].x >> 1));
      end
      rd_key = key(int'(ptf_x), int'(ptf_y));
      rd_data_key = rd_key;
      rd_cnt = READ_LAT;
      rd_pending = 1;
      rg_cyc = cyc;
   endtask

   task do_write();
      wk = key(int'(ptf_x), int'(ptf_y));
      wr_count++;
      if (rd_pending && rd_key == wk) begin
         if (mq.size() < 1) check("write_unexpected", 1, 0);
         else begin
            pa = mq.pop_front();
            check("wr_single_addr", 64'(key(pa.x, pa.y)), 64'(wk));
            exp_w = place(mem_rd(wk), pa.x, pa.p);
            check("wr_single_word", ptf_pixel_write, exp_w);
         end
      end else begin
         if (mq.size() < 2) check("pair_available", 64'(mq.size()), 2);
         else begin
            pa = mq.pop_front();
            pb = mq.pop_front();
            check("pair_partner", 64'(key(pa.x, pa.y) == key(pb.x, pb.y) && (pa.x % 2) != (pb.x % 2)), 1);
            check("pair_addr", 64'(key(pa.x, pa.y)), 64'(wk));
            exp_w = place(place('0, pa.x, pa.p), pb.x, pb.p);
            check("wr_pair_word", ptf_pixel_write, exp_w);
         end
      end
      mem[wk] = ptf_pixel_write;
      rd_pending = 0;
   endtask

   // Memory responder and per-cycle compare, 2 time units after the falling edge
   always begin
      @(negedge clock);
      #2;
      cyc++;
      ptf_pixel_read = GARBAGE;
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) ptf_pixel_read = mem_rd(rd_data_key);
      end
      done_ptf = 1'b0;
      grant = 0;
      if (!reset) begin
         check("rst_ptf_flag", ptf_flag, 0);
         check("rst_ptf_wr", ptf_wr, 0);
         check("rst_ptf_x", 64'(ptf_x), 0);
         check("rst_ptf_y", 64'(ptf_y), 0);
         check("rst_ptf_pixel_write", ptf_pixel_write, 0);
         check("rst_busy", busy, 0);
         check("rst_done_pt", done_pt, 0);
         mq.delete();
         rd_pending = 0; prev_hold = 0; prev_wr_req = 0; req_age = 0; rd_cnt = 0;
      end else begin
         if (prev_hold && ptf_flag) begin
            check("hold_ptf_x", 64'(ptf_x), 64'(h_x));
            check("hold_ptf_y", 64'(ptf_y), 64'(h_y));
            check("hold_ptf_wr", ptf_wr, h_wr);
            check("hold_ptf_pixel_write", ptf_pixel_write, h_wd);
         end
         if (ptf_flag && ptf_wr && !prev_wr_req && rd_pending)
            check("wr_req_after_read_grant", 64'(cyc - rg_cyc), READ_LAT + 1);
         grant = ptf_flag && !frame_flag && (grant_en != 0) && (!ptf_wr || wr_grant_en != 0) &&
                 (req_age >= stall_cfg);
         if (grant) begin
            done_ptf = 1'b1;
            if (ptf_wr) do_write();
            else do_read();
            req_age = 0;
         end else if (ptf_flag) req_age++;
         else req_age = 0;
         prev_hold = ptf_flag && !grant && !frame_flag;
         prev_wr_req = ptf_flag && ptf_wr && !frame_flag;
         h_x = ptf_x; h_y = ptf_y; h_wr = ptf_wr; h_wd = ptf_pixel_write;
         if (frame_flag) begin
            mq.delete();
            rd_pending = 0;
         end
      end
   end

   task automatic push(input int x, input int y, input logic [PIX_W-1:0] p, input bit exp_acc);
      pix_t e;
      pt_flag = 1'b1; pt_x = X_W'(x); pt_y = Y_W'(y); pt_pixel = p;
      #1;
      check("done_pt", done_pt, exp_acc);
      if (done_pt) begin
         e.x = x; e.y = y; e.p = p;
         mq.push_back(e);
      end
      @(negedge clock);
      pt_flag = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clock);
      #1;
      while (busy && n < 300) begin
         @(negedge clock);
         #1;
         n++;
      end
      check({name, "_idle"}, busy, 0);
      check({name, "_queue_drained"}, 64'(mq.size()), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, w0, n;
      #1 reset = 1'b0;
      pt_flag = 1'b1; pt_x = 10'd3; pt_y = 9'd1; pt_pixel = 18'h1;
      repeat (3) @(negedge clock);
      #1;
      check("reset_done_pt", done_pt, 0);
      check("reset_busy", busy, 0);
      check("reset_ptf_flag", ptf_flag, 0);
      @(negedge clock);
      pt_flag = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Single pixel, odd x: high half preserved from memory
      mem[key(4, 3)] = 36'h123456789;
      r0 = rd_count; w0 = wr_count;
      push(5, 3, 18'h2AAAA, 1);
      wait_idle("single");
      check("single_word", mem_rd(key(4, 3)), 36'h12346AAAA);
      check("single_reads", 64'(rd_count - r0), 1);
      check("single_writes", 64'(wr_count - w0), 1);

      // Adjacent pair queued behind a stalled single
      grant_en = 0;
      r0 = rd_count; w0 = wr_count;
      push(20, 2, 18'h00001, 1);
      push(8, 1, 18'h11111, 1);
      push(9, 1, 18'h22222, 1);
      grant_en = 1;
      wait_idle("pair");
      check("pair_word", mem_rd(key(8, 1)), 36'h444462222);
      check("pair_single_word", mem_rd(key(20, 2)), 36'h000040000);
      check("pair_reads", 64'(rd_count - r0), 1);
      check("pair_writes", 64'(wr_count - w0), 2);

      // FIFO full: one in the work register, four queued, fifth refused
      grant_en = 0;
      push(100, 10, 18'h00ABC, 1);
      push(30, 4, 18'h00001, 1);
      push(30, 4, 18'h00002, 1);
      push(40, 5, 18'h3FFFF, 1);
      push(41, 6, 18'h12345, 1);
      push(50, 4, 18'h3C3C3, 0);
      #1;
      check("full_busy", busy, 1);
      grant_en = 1;
      wait_idle("full");
      check("full_w0", mem_rd(key(100, 10)), 36'h02AF00000);
      check("full_dup_last_wins", mem_rd(key(30, 4)), 36'h000080000);
      check("full_w3", mem_rd(key(40, 5)), 36'hFFFFC0000);
      check("full_w4", mem_rd(key(41, 6)), 36'h000012345);
      check("full_refused_absent", 64'(mem.exists(key(50, 4))), 0);

      // Delayed grants on both read and write
      stall_cfg = 3;
      mem[key(6, 7)] = 36'hFFFFFFFFF;
      push(7, 7, 18'h15555, 1);
      wait_idle("delayed");
      check("delayed_word", mem_rd(key(6, 7)), 36'hFFFFD5555);
      stall_cfg = 0;

      // frame_flag while a read is outstanding and two entries queued
      grant_en = 0;
      w0 = wr_count;
      push(50, 8, 18'h00050, 1);
      push(60, 8, 18'h00060, 1);
      push(70, 8, 18'h00070, 1);
      grant_en = 1;
      @(negedge clock);
      frame_flag = 1'b1; pt_flag = 1'b1; pt_x = 10'd90; pt_y = 9'd8; pt_pixel = 18'h00090;
      #1;
      check("frame_done_pt", done_pt, 0);
      @(negedge clock);
      frame_flag = 1'b0; pt_flag = 1'b0;
      #1;
      check("frame_ptf_flag", ptf_flag, 0);
      check("frame_busy", busy, 0);
      repeat (10) @(negedge clock);
      check("frame_no_write", 64'(wr_count - w0), 0);

      // Reset while a write is pending
      wr_grant_en = 0;
      push(80, 9, 18'h1CAFE, 1);
      n = 0;
      #1;
      while (!(ptf_flag && ptf_wr) && n < 50) begin
         @(negedge clock);
         #1;
         n++;
      end
      check("reached_wr_req", 64'(ptf_flag && ptf_wr), 1);
      w0 = wr_count;
      reset = 1'b0; pt_flag = 1'b1;
      #1;
      check("abort_ptf_flag", ptf_flag, 0);
      check("abort_ptf_wr", ptf_wr, 0);
      check("abort_ptf_pixel_write", ptf_pixel_write, 0);
      check("abort_busy", busy, 0);
      check("abort_done_pt", done_pt, 0);
      repeat (2) @(negedge clock);
      reset = 1'b1; pt_flag = 1'b0; wr_grant_en = 1;
      repeat (8) @(negedge clock);
      check("abort_no_retry", 64'(wr_count - w0), 0);
      push(81, 9, 18'h0BEEF, 1);
      wait_idle("after_reset");
      check("after_reset_word", mem_rd(key(80, 9)), 36'h00000BEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
